// File: rtl/rollback_ring_buffer_if.sv
// Handshake bundle for rollback_ring_buffer: alloc, free and rollback
// channels plus status; master drives requests, slave is the buffer.
interface rollback_ring_buffer_if #(
  parameter int NBITS     = 8,
  parameter int IDX_NBITS = 2
);
  logic                 alloc_en;
  logic [NBITS-1:0]     alloc_data;
  logic                 alloc_rdy;
  logic [IDX_NBITS-1:0] alloc_idx;
  logic                 free_en;
  logic                 free_val;
  logic [NBITS-1:0]     free_data;
  logic [IDX_NBITS-1:0] free_idx;
  logic                 rollback_en;
  logic                 rollback_rdy;
  logic [IDX_NBITS:0]   count;
  logic                 empty;
  logic                 full;

  modport master (
    output alloc_en, alloc_data, free_en, rollback_en,
    input  alloc_rdy, alloc_idx, free_val, free_data,
    input  free_idx, rollback_rdy, count, empty, full
  );

  modport slave (
    input  alloc_en, alloc_data, free_en, rollback_en,
    output alloc_rdy, alloc_idx, free_val, free_data,
    output free_idx, rollback_rdy, count, empty, full
  );
endinterface

// File: rtl/rollback_ring_buffer.sv
// Circular in-order tracking store with alloc at tail, free at head and
// rollback of the newest entry. Ports: clk, reset (async, active-low),
// bus (rollback_ring_buffer_if.slave), err only with RING_ERR_FLAG_EN.
module rollback_ring_buffer #(
  parameter int NBITS     = 8,
  parameter int SIZE      = 4,
  parameter int IDX_NBITS = 2
) (
  input  logic clk,
  input  logic reset,
  rollback_ring_buffer_if.slave bus
`ifdef RING_ERR_FLAG_EN
  ,
  output logic err
`endif
);

  localparam logic [IDX_NBITS-1:0] LAST =
    IDX_NBITS'(SIZE - 1);
  localparam logic [IDX_NBITS:0] CNT_FULL =
    (IDX_NBITS + 1)'(SIZE);
  localparam logic [IDX_NBITS:0] CNT_ONE =
    (IDX_NBITS + 1)'(1);

  logic [NBITS-1:0]     mem [SIZE];
  logic [IDX_NBITS-1:0] head;
  logic [IDX_NBITS-1:0] tail;
  logic [IDX_NBITS:0]   count;

  logic                 empty;
  logic                 full;
  logic                 alloc_rdy;
  logic                 rollback_rdy;
  logic                 fire_a;
  logic                 fire_f;
  logic                 fire_r;
  logic [IDX_NBITS-1:0] head_inc;
  logic [IDX_NBITS-1:0] tail_inc;
  logic [IDX_NBITS-1:0] tail_dec;
  logic [IDX_NBITS-1:0] tail_nxt;
  logic [IDX_NBITS:0]   count_nxt;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // Rollback blocks alloc; at one entry a free takes priority.
  assign alloc_rdy    = !full && !bus.rollback_en;
  assign rollback_rdy = (count > CNT_ONE) ||
                        ((count == CNT_ONE) && !bus.free_en);

  assign fire_a = bus.alloc_en && alloc_rdy;
  assign fire_f = bus.free_en && !empty;
  assign fire_r = bus.rollback_en && rollback_rdy;

  // Explicit compare-and-wrap keeps non-power-of-two sizes correct.
  assign head_inc = (head == LAST) ? '0
                  : head + IDX_NBITS'(1);
  assign tail_inc = (tail == LAST) ? '0
                  : tail + IDX_NBITS'(1);
  assign tail_dec = (tail == '0) ? LAST
                  : tail - IDX_NBITS'(1);

  always_comb begin
    tail_nxt = tail;
    unique case (1'b1)
      fire_r:  tail_nxt = tail_dec;
      fire_a:  tail_nxt = tail_inc;
      default: tail_nxt = tail;
    endcase
  end

  assign count_nxt = count
                   + (IDX_NBITS + 1)'(fire_a)
                   - (IDX_NBITS + 1)'(fire_f)
                   - (IDX_NBITS + 1)'(fire_r);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < SIZE; i++) mem[i] <= '0;
    end else begin
      if (fire_a) mem[tail] <= bus.alloc_data;
      if (fire_f) head <= head_inc;
      tail  <= tail_nxt;
      count <= count_nxt;
    end
  end

`ifdef RING_ERR_FLAG_EN
  logic bad_req;

  // Only structurally impossible requests; priority refusals are legal.
  assign bad_req = (bus.alloc_en && full) ||
                   (bus.free_en && empty) ||
                   (bus.rollback_en && empty);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else if (bad_req) err <= 1'b1;
  end
`endif

  assign bus.alloc_rdy    = alloc_rdy;
  assign bus.alloc_idx    = tail;
  assign bus.free_val     = !empty;
  assign bus.free_data    = mem[head];
  assign bus.free_idx     = head;
  assign bus.rollback_rdy = rollback_rdy;
  assign bus.count        = count;
  assign bus.empty        = empty;
  assign bus.full         = full;

endmodule

// File: tb/tb_rollback_ring_buffer.sv
// Self-checking bench for rollback_ring_buffer: directed scenarios plus
// randomized traffic against an occupancy/head reference model.
module tb_rollback_ring_buffer;
  localparam int SZ = 4;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  rollback_ring_buffer_if #(.NBITS(8), .IDX_NBITS(2)) bus ();

`ifdef RING_ERR_FLAG_EN
  logic err;
  logic m_err;
  rollback_ring_buffer #(.NBITS(8), .SIZE(SZ), .IDX_NBITS(2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .err(err)
  );
`else
  rollback_ring_buffer #(.NBITS(8), .SIZE(SZ), .IDX_NBITS(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: contents, oldest index and occupancy.
  logic [7:0] m_mem [SZ];
  int         m_head;
  int         m_count;

  logic       e_ardy, e_rrdy, o_ardy, o_rrdy;

  function automatic int m_tail();
    return (m_head + m_count) % SZ;
  endfunction

  function automatic logic [18:0] exp_vec();
    logic [2:0] c;
    logic [1:0] h;
    logic [1:0] t;
    c = 3'(m_count);
    h = 2'(m_head);
    t = 2'(m_tail());
    return {c, m_count == 0, m_count == SZ, m_count != 0,
            h, t, m_mem[m_head]};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {bus.count, bus.empty, bus.full, bus.free_val,
            bus.free_idx, bus.alloc_idx, bus.free_data};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SZ; i++) m_mem[i] = 8'h00;
    m_head  = 0;
    m_count = 0;
`ifdef RING_ERR_FLAG_EN
    m_err = 1'b0;
`endif
  endtask

  // Drive one cycle of requests (called at posedge+1), advance model.
  task automatic step(input logic a, input logic [7:0] d,
                      input logic f, input logic r);
    bit fa, ff, fr;
    int t0;
    bus.alloc_en    = a;
    bus.alloc_data  = d;
    bus.free_en     = f;
    bus.rollback_en = r;
    e_ardy = (m_count < SZ) && !r;
    e_rrdy = (m_count >= 2) || (m_count == 1 && !f);
    fa = a && e_ardy;
    ff = f && (m_count > 0);
    fr = r && e_rrdy;
`ifdef RING_ERR_FLAG_EN
    if ((a && m_count == SZ) || ((f || r) && m_count == 0))
      m_err = 1'b1;
`endif
    #2;
    o_ardy = bus.alloc_rdy;
    o_rrdy = bus.rollback_rdy;
    @(posedge clk);
    #1;
    t0 = m_tail();
    if (fa) m_mem[t0] = d;
    if (ff) m_head = (m_head + 1) % SZ;
    m_count = m_count + int'(fa) - int'(ff) - int'(fr);
    bus.alloc_en    = 1'b0;
    bus.free_en     = 1'b0;
    bus.rollback_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.alloc_en = 1'b0;
    bus.alloc_data = 8'h00;
    bus.free_en = 1'b0;
    bus.rollback_en = 1'b0;
    model_reset();
    #3;
    compared++;
    if (obs_vec() !== 19'b000_1_0_0_00_00_00000000) begin
      mismatched++;
      $display("FAIL reset_state: got %h want %h", obs_vec(),
               19'b000_1_0_0_00_00_00000000);
    end
    compared++;
    if ({bus.alloc_rdy, bus.rollback_rdy} !== 2'b10) begin
      mismatched++;
      $display("FAIL reset_rdy: got %b want 10",
               {bus.alloc_rdy, bus.rollback_rdy});
    end
    #9 reset = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (obs_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL idle_after_reset: got %h want %h",
               obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fill();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) step(1'b1, vals[i], 1'b0, 1'b0);
    compared++;
    if ({bus.full, bus.alloc_rdy, bus.count} !== 5'b1_0_100) begin
      mismatched++;
      $display("FAIL fill_full: got %b want 10100",
               {bus.full, bus.alloc_rdy, bus.count});
    end
    compared++;
    if ({bus.free_data, bus.alloc_idx} !== {8'h11, 2'd0}) begin
      mismatched++;
      $display("FAIL fill_head: got %h/%0d want 11/0",
               bus.free_data, bus.alloc_idx);
    end
  endtask

  task automatic test_rollback();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    compared++;
    if ({bus.alloc_idx, bus.count, bus.free_data}
        !== {2'd0, 3'd2, 8'h33}) begin
      mismatched++;
      $display("FAIL rollback: got idx %0d cnt %0d data %h want 0 2 33",
               bus.alloc_idx, bus.count, bus.free_data);
    end
  endtask

  task automatic test_rollback_wrap();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    compared++;
    if ({bus.alloc_idx, bus.count} !== {2'd3, 3'd1}) begin
      mismatched++;
      $display("FAIL rollback_wrap: got idx %0d cnt %0d want 3 1",
               bus.alloc_idx, bus.count);
    end
    step(1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    compared++;
    if ({bus.free_idx, bus.free_data, bus.count}
        !== {2'd3, 8'h66, 3'd1}) begin
      mismatched++;
      $display("FAIL wrap_alloc: got h %0d d %h c %0d want 3 66 1",
               bus.free_idx, bus.free_data, bus.count);
    end
  endtask

  task automatic test_free_vs_rollback();
    step(1'b0, 8'h00, 1'b1, 1'b1);
    compared++;
    if (o_rrdy !== 1'b0) begin
      mismatched++;
      $display("FAIL fr_rrdy: got %b want 0", o_rrdy);
    end
    compared++;
    if ({bus.count, bus.empty} !== {3'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL fr_count: got %0d/%b want 0/1",
               bus.count, bus.empty);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom),
           1'($urandom_range(0, 99) < 35),
           1'($urandom_range(0, 99) < 20));
      compared++;
      if ({o_ardy, o_rrdy} !== {e_ardy, e_rrdy}) begin
        mismatched++;
        $display("FAIL rand_rdy[%0d]: got %b want %b", n,
                 {o_ardy, o_rrdy}, {e_ardy, e_rrdy});
      end
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL rand_state[%0d]: got %h want %h", n,
                 obs_vec(), exp_vec());
      end
`ifdef RING_ERR_FLAG_EN
      compared++;
      if (err !== m_err) begin
        mismatched++;
        $display("FAIL rand_err[%0d]: got %b want %b", n, err, m_err);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    reset = 1'b0;
    #3 reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    compared++;
    if (bus.count !== 3'd3) begin
      mismatched++;
      $display("FAIL pre_reset_count: got %0d want 3", bus.count);
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    compared++;
    if (obs_vec() !== 19'b000_1_0_0_00_00_00000000) begin
      mismatched++;
      $display("FAIL async_reset: got %h want %h", obs_vec(),
               19'b000_1_0_0_00_00_00000000);
    end
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifdef RING_ERR_FLAG_EN
  task automatic test_err();
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL err_clear: got %b want 0", err);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL err_set: got %b want 1", err);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_fill();
    test_rollback();
    test_rollback_wrap();
    test_free_vs_rollback();
    test_random();
    test_async_reset();
`ifdef RING_ERR_FLAG_EN
    test_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
